// File: rtl/shift_seq_pkg.sv
// Shared types and widths for the iterative shift sequencer.
package shift_seq_pkg;

  localparam int DATA_W = 32;
  localparam int OPND_W = 12;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    LSL,
    LSR,
    ASR,
    ROR
  } op_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 1 or 2 bit positions.
module shift_step
  import shift_seq_pkg::*;
(
  input  logic [DATA_W-1:0] acc,
  input  logic [1:0]        op,
  input  logic              two,
  output logic [DATA_W-1:0] next
);

  always_comb begin
    next = acc;
    unique case (op)
      LSL: next = two ? {acc[29:0], 2'b00}
                      : {acc[30:0], 1'b0};
      LSR: next = two ? {2'b00, acc[31:2]}
                      : {1'b0, acc[31:1]};
      ASR: next = two ? {{2{acc[31]}}, acc[31:2]}
                      : {acc[31], acc[31:1]};
      ROR: next = two ? {acc[1:0], acc[31:2]}
                      : {acc[0], acc[31:1]};
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative barrel-shift replacement; optional 2-bit stepping
// is enabled by defining SHIFT_SEQ_DOUBLE_STEP_EN.
module shift_sequencer
  import shift_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] rm,
  input  logic [OPND_W-1:0] shift_operand,
  input  logic              imm,
  input  logic              mem_en,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  state_t            state;
  op_t               op;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  count;

  logic [DATA_W-1:0] ld_acc;
  op_t               ld_op;
  logic [CNT_W-1:0]  ld_n;

  logic              two;
  logic [CNT_W-1:0]  step_n;
  logic [DATA_W-1:0] next_acc;

  // mem_en wins over imm
  always_comb begin
    ld_acc = rm;
    ld_op  = op_t'(shift_operand[6:5]);
    ld_n   = shift_operand[11:7];
    if (mem_en) begin
      ld_acc = {20'b0, shift_operand};
      ld_op  = LSL;
      ld_n   = '0;
    end else if (imm) begin
      ld_acc = {24'b0, shift_operand[7:0]};
      ld_op  = ROR;
      ld_n   = {shift_operand[11:8], 1'b0};
    end
  end

`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
  assign two = (count >= 5'd2);
`else
  assign two = 1'b0;
`endif

  assign step_n = two ? 5'd2 : 5'd1;

  shift_step u_step (
    .acc  (acc),
    .op   (op),
    .two  (two),
    .next (next_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op    <= LSL;
      acc   <= '0;
      count <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          acc   <= ld_acc;
          op    <= ld_op;
          count <= ld_n;
          state <= (ld_n == '0) ? DONE : SHIFT;
        end
        SHIFT: begin
          acc   <= next_acc;
          count <= count - step_n;
          if (count == step_n)
            state <= DONE;
        end
        DONE: if (rsp_ready)
          state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign rsp_data  = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: vector table,
// random transactions against a reference model, corner sequences.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] rm;
  logic [11:0] shift_operand;
  logic        imm;
  logic        mem_en;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;

  int checks = 0;
  int passes = 0;

  shift_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .rm            (rm),
    .shift_operand (shift_operand),
    .imm           (imm),
    .mem_en        (mem_en),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic        i;
    logic [31:0] r;
    logic [11:0] so;
    logic [31:0] exp;
    int          n;
  } vec_t;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] ror(logic [31:0] v, int n);
    logic [63:0] d;
    d = {v, v} >> n;
    return d[31:0];
  endfunction

  function automatic int amount(logic m, logic i,
                                logic [11:0] so);
    if (m) return 0;
    if (i) return 2 * int'(so[11:8]);
    return int'(so[11:7]);
  endfunction

  function automatic logic [31:0] model(logic m, logic i,
      logic [31:0] r, logic [11:0] so);
    int n;
    logic signed [31:0] s;
    n = amount(m, i, so);
    s = r;
    if (m) return {20'b0, so};
    if (i) return ror({24'b0, so[7:0]}, n);
    case (so[6:5])
      2'd0: return r << n;
      2'd1: return r >> n;
      2'd2: return s >>> n;
      default: return ror(r, n);
    endcase
  endfunction

  function automatic int exp_lat(int n);
`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
    return 1 + (n + 1) / 2;
`else
    return 1 + n;
`endif
  endfunction

  task automatic scramble();
    rm            = $urandom;
    shift_operand = 12'($urandom);
    imm           = 1'($urandom);
    mem_en        = 1'($urandom);
  endtask

  task automatic wait_rsp(inout int lat);
    while (!rsp_valid && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // issue one request and wait for its result (rsp_ready=1)
  task automatic run_op(input logic m, input logic i,
      input logic [31:0] r, input logic [11:0] so,
      output logic [31:0] data, output int lat);
    @(negedge clk);
    mem_en = m; imm = i; rm = r; shift_operand = so;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();
    lat = 1;
    wait_rsp(lat);
    data = rsp_data;
  endtask

  vec_t        vt[12];
  logic [31:0] d, d0, ea, eb;
  int          lat, na, nb;
  logic        seen;

  initial begin
    vt[0]  = '{1, 0, 32'h0,        12'hABC, 32'h00000ABC, 0};
    vt[1]  = '{0, 1, 32'h0,        12'h1FF, 32'hC000003F, 2};
    vt[2]  = '{0, 0, 32'h80000001, 12'h240, 32'hF8000000, 4};
    vt[3]  = '{0, 0, 32'h12345678, 12'h460, 32'h78123456, 8};
    vt[4]  = '{0, 0, 32'hDEADBEEF, 12'h000, 32'hDEADBEEF, 0};
    vt[5]  = '{0, 0, 32'h00000001, 12'h060, 32'h00000001, 0};
    vt[6]  = '{0, 1, 32'hFFFFFFFF, 12'h0A5, 32'h000000A5, 0};
    vt[7]  = '{0, 0, 32'h80000000, 12'hFA0, 32'h00000001, 31};
    vt[8]  = '{0, 1, 32'h0,        12'hF01, 32'h00000004, 30};
    vt[9]  = '{1, 1, 32'h55555555, 12'hFFF, 32'h00000FFF, 0};
    vt[10] = '{0, 0, 32'h00000003, 12'hF80, 32'h80000000, 31};
    vt[11] = '{0, 0, 32'h7FFFFFFF, 12'h0C0, 32'h3FFFFFFF, 1};

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    rm = '0; shift_operand = '0; imm = 1'b0; mem_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      run_op(vt[k].m, vt[k].i, vt[k].r, vt[k].so, d, lat);
      chk($sformatf("vec%0d_data", k), d, vt[k].exp);
      chk($sformatf("vec%0d_lat", k), 32'(lat),
          32'(exp_lat(vt[k].n)));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_idle", k), 32'(req_ready), 32'd1);
    end

    for (int k = 0; k < 40; k++) begin
      logic        m, i;
      logic [31:0] r;
      logic [11:0] so;
      m = ($urandom_range(0, 5) == 0);
      i = 1'($urandom);
      r = $urandom;
      so = 12'($urandom);
      run_op(m, i, r, so, d, lat);
      chk($sformatf("rnd%0d_data", k), d, model(m, i, r, so));
      chk($sformatf("rnd%0d_lat", k), 32'(lat),
          32'(exp_lat(amount(m, i, so))));
      @(posedge clk); #1;
    end

    // result held while the consumer stalls
    rsp_ready = 1'b0;
    run_op(1'b0, 1'b0, 32'h12345678, 12'h460, d0, lat);
    chk("hold_data", d0, 32'h78123456);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_data", k), rsp_data, d0);
      chk($sformatf("hold%0d_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("hold%0d_ready", k), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_valid", 32'(rsp_valid), 32'd0);
    chk("hold_release_ready", 32'(req_ready), 32'd1);

    // reset during LSL #31, at the 10th shift edge
    @(negedge clk);
    mem_en = 1'b0; imm = 1'b0; rm = 32'hA5A5A5A5;
    shift_operand = 12'hF80; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("rst_inflight_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("rst_no_response", 32'(seen), 32'd0);

    // back-to-back with req_valid held high
    ea = model(1'b0, 1'b0, 32'h0000F00F, 12'h1A0);
    eb = model(1'b0, 1'b1, 32'h0,        12'h3C3);
    na = amount(1'b0, 1'b0, 12'h1A0);
    nb = amount(1'b0, 1'b1, 12'h3C3);
    @(negedge clk);
    mem_en = 1'b0; imm = 1'b0; rm = 32'h0000F00F;
    shift_operand = 12'h1A0; req_valid = 1'b1;
    @(posedge clk); #1;
    imm = 1'b1; rm = 32'h0; shift_operand = 12'h3C3;
    lat = 1;
    wait_rsp(lat);
    chk("b2b_a_data", rsp_data, ea);
    chk("b2b_a_lat", 32'(lat), 32'(exp_lat(na)));
    @(posedge clk); #1;
    chk("b2b_gap_valid", 32'(rsp_valid), 32'd0);
    chk("b2b_gap_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_b_accept", 32'(busy), 32'd1);
    lat = 1;
    wait_rsp(lat);
    chk("b2b_b_data", rsp_data, eb);
    chk("b2b_b_lat", 32'(lat), 32'(exp_lat(nb)));
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
